// File: rtl/sega_pad_scanner.sv
// sega_pad_scanner: scans a Sega 3/6-button pad and publishes button status and pad type once per frame
module sega_pad_scanner #(
   parameter int STEP_DIV   = 500,
   parameter int IDLE_STEPS = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  sj,
   output logic        sel,
   output logic [11:0] status,
   output logic [1:0]  pad_type,
   output logic        frame_done
);
   localparam int PW = $clog2(STEP_DIV);
   localparam int IW = $clog2(IDLE_STEPS + 1);
   typedef enum logic [3:0] {IDLE, P0, P1, P2, P3, P4, P5, P6, P7} state_t;
   state_t          state, nxt;
   logic [5:0]      sync1, sync2, s;
   logic [PW-1:0]   pre;
   logic [IW-1:0]   idle_cnt;
   logic [11:0]     shadow;
   logic            present, six, tick;
   assign s = ~sync2;
   // two-flop synchronizer for the asynchronous pad lines, idling at released (all high)
   always_ff @(posedge clk or posedge reset)
      if (reset) {sync2, sync1} <= '1;
      else {sync2, sync1} <= {sync1, sj};
   // step prescaler; it wraps on the tick, which is also the only edge the state can change on
   always_ff @(posedge clk or posedge reset)
      if (reset) pre <= '0;
      else pre <= tick ? '0 : pre + 1'b1;
   // tick marks the last clk edge of a step; nxt is the state entered on that edge
   always_comb begin
      tick = pre == PW'(STEP_DIV - 1);
      nxt = (state == P7) ? IDLE :
            (state == IDLE) ? ((idle_cnt == IW'(IDLE_STEPS - 1)) ? P0 : IDLE) :
            state_t'(state + 4'd1);
   end
   // protocol FSM: drives sel, samples the pad at the end of each step, commits the frame in P7
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         idle_cnt   <= '0;
         sel        <= 1'b1;
         shadow     <= '0;
         present    <= 1'b0;
         six        <= 1'b0;
         status     <= '0;
         pad_type   <= 2'b00;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (tick) begin
            state    <= nxt;
            sel      <= nxt inside {IDLE, P0, P2, P4, P6};
            idle_cnt <= (state == IDLE && nxt == IDLE) ? idle_cnt + 1'b1 : '0;
            case (state)
               IDLE: if (nxt == P0) begin
                  present <= 1'b0;
                  six     <= 1'b0;
               end
               P0: shadow[5:0] <= s;
               P1: begin
                  present     <= &s[3:2];
                  shadow[7:6] <= s[5:4];
               end
               P5: six <= &s[3:0];
               P6: shadow[11:8] <= six ? s[3:0] : 4'h0;
               P7: begin
                  status     <= !present ? 12'h000 : six ? shadow : {4'h0, shadow[7:0]};
                  pad_type   <= !present ? 2'b00 : six ? 2'b10 : 2'b01;
                  frame_done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
endmodule

// File: tb/tb_sega_pad_scanner.sv
// tb_sega_pad_scanner: randomized self-checking bench with a behavioural Sega pad and frame-level reference model
module tb_sega_pad_scanner;
   localparam int SD = 4;
   localparam int IS = 2;
   localparam int FP = (8 + IS) * SD;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  sj = 6'h3F;
   logic        sel;
   logic [11:0] status;
   logic [1:0]  pad_type;
   logic        frame_done;
   int          tests = 0;
   int          fails = 0;
   logic [11:0] btn = '0;
   logic [1:0]  ptype = 2'd0;
   int          phase = 0;
   int          hi_cnt = 0;
   logic        sel_q = 1'b1;
   bit          glitch = 1'b0;
   logic [11:0] prev_s = '0;
   logic [1:0]  prev_t = '0;
   logic        rst_q = 1'b1;

   sega_pad_scanner #(.STEP_DIV(SD), .IDLE_STEPS(IS)) dut (
      .clk(clk), .reset(reset), .sj(sj), .sel(sel),
      .status(status), .pad_type(pad_type), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // pad line levels for a given sel-edge phase; ptype 0 = unplugged, 1 = 3-button, 2 = 6-button
   function automatic logic [5:0] pad_out(int ph, logic sl, logic [11:0] b, logic [1:0] t);
      logic [5:0] v;
      if (t == 2'd0) return 6'h3F;
      if (sl) v = {b[5:4], (t == 2'd2 && ph == 6) ? b[11:8] : b[3:0]};
      else v = {b[7:6], (t == 2'd2 && ph == 5) ? 4'hF : {2'b11, b[1:0]}};
      return ~v;
   endfunction

   // expected {pad_type, status} for a whole frame with a steady pad; a 3-button pad holding UP+DN reads as 6-button
   function automatic logic [13:0] expect_frame(logic [11:0] b, logic [1:0] t);
      logic six;
      if (t == 2'd0) return 14'h0;
      six = (t == 2'd2) || (b[1:0] == 2'b11);
      return six ? {2'b10, (t == 2'd2) ? b[11:8] : b[3:0], b[7:0]} : {2'b01, 4'h0, b[7:0]};
   endfunction

   // pad model: counts sel transitions, and a long sel-high period rewinds it to phase 0
   always @(posedge clk) begin
      #1;
      if (sel !== sel_q) begin
         phase++;
         hi_cnt = 0;
      end else if (sel) begin
         if (hi_cnt < 6) hi_cnt++;
         else phase = 0;
      end
      sel_q = sel;
      sj = pad_out(phase, sel, btn, ptype);
   end

   // outputs may only move together with frame_done (or under reset), and pad_type 11 must never appear
   always @(negedge clk) begin
      if (!reset && !rst_q) begin
         if (pad_type == 2'b11) glitch = 1'b1;
         if ((status !== prev_s || pad_type !== prev_t) && !frame_done) glitch = 1'b1;
      end
      rst_q = reset;
      prev_s = status;
      prev_t = pad_type;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
      $fatal(1);
   end

   task automatic wait_fd(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 4 * FP);
   endtask

   task automatic test_reset;
      logic es;
      reset = 1'b1;
      btn = '0;
      ptype = 2'd0;
      repeat (3) @(negedge clk);
      tests++;
      if ({sel, frame_done, pad_type, status} !== 16'h8000) begin
         fails++;
         $display("FAIL reset_state: sel=%b fd=%b type=%b status=%h, required 1 0 00 000", sel, frame_done, pad_type, status);
      end
      reset = 1'b0;
      for (int k = 1; k <= FP; k++) begin
         @(negedge clk);
         es = (k < IS * SD) || (((k - IS * SD) / SD) % 2 == 0);
         tests++;
         if ({sel, frame_done} !== {es, k == FP}) begin
            fails++;
            $display("FAIL first_frame_wave cycle %0d: sel=%b fd=%b, required sel=%b fd=%b", k, sel, frame_done, es, k == FP);
         end
      end
      tests++;
      if ({pad_type, status} !== 14'h0) begin
         fails++;
         $display("FAIL no_pad_commit: type=%b status=%h, required 00 000", pad_type, status);
      end
   endtask

   task automatic test_fixed(string name, logic [11:0] b, logic [1:0] t, logic [13:0] req);
      int n;
      btn = b;
      ptype = t;
      wait_fd(n);
      tests++;
      if (frame_done !== 1'b1 || {pad_type, status} !== req) begin
         fails++;
         $display("FAIL %s: fd=%b type=%b status=%h, required fd=1 type=%b status=%h", name, frame_done, pad_type, status, req[13:12], req[11:0]);
      end
   endtask

   task automatic test_random;
      int n;
      logic [13:0] e;
      for (int i = 0; i < 16; i++) begin
         btn = 12'($urandom);
         ptype = 2'($urandom_range(0, 2));
         e = expect_frame(btn, ptype);
         wait_fd(n);
         tests++;
         if (frame_done !== 1'b1 || n != FP || {pad_type, status} !== e) begin
            fails++;
            $display("FAIL random_frame %0d: fd=%b period=%0d type=%b status=%h, required fd=1 period=%0d type=%b status=%h",
                     i, frame_done, n, pad_type, status, FP, e[13:12], e[11:0]);
         end
      end
   endtask

   task automatic test_unplug;
      int n;
      logic [13:0] e;
      btn = 12'($urandom);
      ptype = 2'd2;
      e = expect_frame(btn, ptype);
      wait_fd(n);
      tests++;
      if (frame_done !== 1'b1 || {pad_type, status} !== e) begin
         fails++;
         $display("FAIL unplug_before: type=%b status=%h, required type=%b status=%h", pad_type, status, e[13:12], e[11:0]);
      end
      repeat (21) @(negedge clk);
      ptype = 2'd0;
      wait_fd(n);
      tests++;
      if (frame_done !== 1'b1 || n != FP - 21 || {pad_type, status} !== {2'b01, 4'h0, btn[7:0]}) begin
         fails++;
         $display("FAIL unplug_mid: fd=%b wait=%0d type=%b status=%h, required fd=1 wait=%0d type=01 status=%h",
                  frame_done, n, pad_type, status, FP - 21, {4'h0, btn[7:0]});
      end
      wait_fd(n);
      tests++;
      if (frame_done !== 1'b1 || {pad_type, status} !== 14'h0) begin
         fails++;
         $display("FAIL unplug_after: fd=%b type=%b status=%h, required fd=1 type=00 status=000", frame_done, pad_type, status);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      int fd_seen;
      logic [13:0] e;
      btn = 12'($urandom) | 12'h001;
      ptype = 2'd2;
      e = expect_frame(btn, ptype);
      wait_fd(n);
      tests++;
      if (frame_done !== 1'b1 || {pad_type, status} !== e) begin
         fails++;
         $display("FAIL reset_mid_before: type=%b status=%h, required type=%b status=%h", pad_type, status, e[13:12], e[11:0]);
      end
      repeat (25) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({sel, frame_done, pad_type, status} !== 16'h8000) begin
         fails++;
         $display("FAIL reset_mid_async: sel=%b fd=%b type=%b status=%h, required 1 0 00 000", sel, frame_done, pad_type, status);
      end
      fd_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (frame_done) fd_seen++;
      end
      tests++;
      if (fd_seen != 0) begin
         fails++;
         $display("FAIL reset_mid_hold: %0d frame_done pulses under reset, required 0", fd_seen);
      end
      reset = 1'b0;
      wait_fd(n);
      tests++;
      if (frame_done !== 1'b1 || n != FP || {pad_type, status} !== e) begin
         fails++;
         $display("FAIL reset_mid_after: fd=%b latency=%0d type=%b status=%h, required fd=1 latency=%0d type=%b status=%h",
                  frame_done, n, pad_type, status, FP, e[13:12], e[11:0]);
      end
   endtask

   task automatic test_period;
      int n;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests++;
         if (frame_done !== 1'b0) begin
            fails++;
            $display("FAIL fd_width frame %0d: fd=%b one cycle after pulse, required 0", i, frame_done);
         end
         n = 1;
         while (!frame_done && n < 4 * FP) begin
            @(negedge clk);
            n++;
         end
         tests++;
         if (frame_done !== 1'b1 || n != FP) begin
            fails++;
            $display("FAIL frame_period %0d: fd=%b period=%0d, required fd=1 period=%0d", i, frame_done, n, FP);
         end
      end
   endtask

   task automatic test_glitch;
      tests++;
      if (glitch) begin
         fails++;
         $display("FAIL output_stability: glitch=%b, required 0", glitch);
      end
   endtask

   initial begin
      test_reset;
      test_fixed("three_button", 12'h0C1, 2'd1, {2'b01, 12'h0C1});
      test_fixed("six_button", 12'hC08, 2'd2, {2'b10, 12'hC08});
      test_fixed("three_button_updn", 12'hF03, 2'd1, {2'b10, 12'h303});
      test_fixed("unplugged", 12'hFFF, 2'd0, 14'h0);
      test_random;
      test_unplug;
      test_reset_mid;
      test_period;
      test_glitch;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
